mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port data `memory_bank` between requester 0 (CPU load/store unit) and requester 1 (DMA/debug port). It grants at most one access per cycle with round-robin fairness and an optional bounded lock for atomic sequences. It drives the bank's `w_en`/`addr`/`d_in` and registers `d_out` into a per-requester read response. It sits between the core datapath and the `memory_bank` instance and is wired to the bank at integration level, not instantiated inside it.

## Interface
- `WORD_SIZE`, default `` `DATA_WORD_SIZE ``: data width.
- `ADDR_SIZE`, default `` `DATA_ADDR_SIZE ``: address width.
- `MAX_LOCK`, default 8: maximum number of cycles a lock is honoured while the other requester waits; must be ≥1.

- `clk` in 1: clock; everything updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `rK_req` in 1 (K=0,1): access request.
- `rK_we` in 1: 1 = write, 0 = read.
- `rK_lock` in 1: request to keep ownership after this access.
- `rK_addr` in ADDR_SIZE: access address.
- `rK_wdata` in WORD_SIZE: write data.
- `rK_gnt` out 1: the access is performed this cycle (combinational).
- `rK_rvalid` out 1: read data is valid (registered, one-cycle pulse).
- `rK_rdata` out WORD_SIZE: read data (registered, held until the next read response).
- `mem_w_en` out 1: write enable to the bank.
- `mem_addr` out ADDR_SIZE: address to the bank.
- `mem_d_in` out WORD_SIZE: write data to the bank.
- `mem_d_out` in WORD_SIZE: combinational read data from the bank.

## Operation
- The requester holds `req`/`we`/`addr`/`wdata`/`lock` stable until it sees `gnt`=1 in a cycle. That cycle is the access. It may deassert `req` or present a new access the following cycle.
- Bank drive:
  - Granted requester's `addr`/`wdata` go to `mem_addr`/`mem_d_in`; `mem_w_en` = gnt & we.
  - With no grant, all three are 0.
- States are IDLE, LOCK0 and LOCK1 (2-bit `state`). There is also a round-robin pointer `rr` (1 bit; holds the index of the preferred requester) and a lock counter `lcnt` (width `$clog2(MAX_LOCK+1)`).
- IDLE:
  - Only one `req` high: grant it.
  - Both high: grant `rr`.
  - After any grant, `rr` ← other index.
  - A granted access with `lock`=1 → LOCKk, `lcnt` ← 0.
- LOCKk:
  - Only requester k may be granted; `lcnt` increments every cycle and saturates at MAX_LOCK.
  - Granted access from k with `lock`=0 → IDLE.
  - Granted access from k with `lock`=1 → stay in LOCKk.
  - Break: if `lcnt`==MAX_LOCK and the other requester j has `req`=1, grant j instead of k. Next state is LOCKj (`lcnt` ← 0) if `rj_lock`, else IDLE. `rr` ← k.
  - A cycle with no grant (k idle, break not met) leaves the state unchanged.
- Read response: a granted read latches `mem_d_out` into `rK_rdata` and pulses `rK_rvalid` the next cycle. Writes produce no response.
- Ordering: a read granted the cycle after a write to the same address returns the new data.

## Timing
- Grant latency: 0 cycles (same cycle as `req` when chosen). Read data latency: 1 cycle after `gnt`.
- Throughput: one access per cycle, total across both requesters. Back-to-back reads by one requester give consecutive `rvalid` pulses.
- Reset (`rst_n`=0 at an edge):
  - `state`=IDLE, `rr`=0, `lcnt`=0.
  - `rK_rvalid`=0 and `rK_rdata`=0.
  - While `rst_n`=0: `rK_gnt`=0, `mem_w_en`=0, `mem_addr`=0, `mem_d_in`=0.
  - Reset mid-operation drops any pending `rvalid` and releases any lock. A write presented during reset never reaches the bank.
- Fairness bound: a requester waiting behind a lock is granted within MAX_LOCK+1 cycles.

## Structure
- Add to `constants.v`:
  - `` `ARB_IDLE ``=2'd0, `` `ARB_LOCK0 ``=2'd1, `` `ARB_LOCK1 ``=2'd2.
  - `` `MEM_ARB_MAX_LOCK ``=8.
- Sub-module `rr_arbiter2`:
  - Holds the `rr` pointer register.
  - Has a `mask` input for lock/break gating.
  - Produces a one-hot grant and the next pointer.
- `mem_arbiter` holds the lock FSM, `lcnt`, bank muxing and the response registers.

## Test plan
- Write, then read: R0 writes 0xA5 to addr 3; next cycle R0 reads addr 3 → `r0_gnt` is 1 in both cycles, and `r0_rvalid`=1 with `r0_rdata`=0xA5 one cycle after the read grant.
- Round-robin: both requesters read every cycle after reset → grants go R0, R1, R0, R1; each `rvalid` arrives one cycle after its `gnt`, and `mem_w_en` stays 0.
- Lock: R1 is granted with `lock`=1, then keeps `lock`=1 while R0 requests continuously (MAX_LOCK=8) → R0 is held off, then granted on the first cycle with `lcnt`==8 (the 9th cycle after entering LOCK1), and `state` returns to IDLE.
- Lock release: R0 is locked for 3 accesses, then the 4th access has `lock`=0 → R1 is granted on the following cycle.
- Reset mid-read: R0 is granted a read, and `rst_n`=0 at the next edge → `r0_rvalid` stays 0. A write held by R1 during reset leaves the bank unchanged.
- Idle: no `req` for 5 cycles → no grants, `mem_w_en`=0, `mem_addr`=0, `state`=IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Lock state encoding matches the ARB_* values used elsewhere in the core.
package mem_arbiter_pkg;

    localparam int DATA_WORD_SIZE   = 16;
    localparam int DATA_ADDR_SIZE   = 8;
    localparam int MEM_ARB_MAX_LOCK = 8;

    typedef logic [1:0] req_vec_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t lockStateOf(input logic idx);
        return idx ? ARB_LOCK1 : ARB_LOCK0;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker: grants among masked requests and keeps the
// preferred-requester pointer, which moves to the loser after every grant.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  req_vec_t i_req,
    input  req_vec_t i_mask,
    output req_vec_t o_gnt
);

    logic     r_ptr;
    logic     w_nextPtr;
    req_vec_t w_eligible;

    always_comb begin
        w_eligible = i_req & i_mask;
        o_gnt      = 2'b00;
        case (w_eligible)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
        w_nextPtr = r_ptr;
        if (o_gnt[0]) begin
            w_nextPtr = 1'b1;
        end else if (o_gnt[1]) begin
            w_nextPtr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else begin
            r_ptr <= w_nextPtr;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data bank between the CPU LSU (port 0) and the
// DMA/debug port (port 1), with round-robin fairness and bounded locking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = DATA_WORD_SIZE,
    parameter int ADDR_SIZE = DATA_ADDR_SIZE,
    parameter int MAX_LOCK  = MEM_ARB_MAX_LOCK
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 r0_req,
    input  logic                 r0_we,
    input  logic                 r0_lock,
    input  logic [ADDR_SIZE-1:0] r0_addr,
    input  logic [WORD_SIZE-1:0] r0_wdata,
    output logic                 r0_gnt,
    output logic                 r0_rvalid,
    output logic [WORD_SIZE-1:0] r0_rdata,
    input  logic                 r1_req,
    input  logic                 r1_we,
    input  logic                 r1_lock,
    input  logic [ADDR_SIZE-1:0] r1_addr,
    input  logic [WORD_SIZE-1:0] r1_wdata,
    output logic                 r1_gnt,
    output logic                 r1_rvalid,
    output logic [WORD_SIZE-1:0] r1_rdata,
    output logic                 mem_w_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_d_in,
    input  logic [WORD_SIZE-1:0] mem_d_out
);

    localparam int LCNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t          r_state;
    logic [LCNT_W-1:0]   r_lcnt;
    logic [1:0]          r_rvalid;
    logic [WORD_SIZE-1:0] r_rdata0;
    logic [WORD_SIZE-1:0] r_rdata1;

    req_vec_t w_req;
    req_vec_t w_weIn;
    req_vec_t w_mask;
    req_vec_t w_gnt;
    logic     w_locked;
    logic     w_owner;
    logic     w_lockExpired;
    logic     w_break;
    logic     w_anyGnt;
    logic     w_gntIdx;
    logic     w_gntLock;

    assign w_req         = {r1_req, r0_req};
    assign w_weIn        = {r1_we, r0_we};
    assign w_locked      = (r_state == ARB_LOCK0) || (r_state == ARB_LOCK1);
    assign w_owner       = (r_state == ARB_LOCK1);
    assign w_lockExpired = (r_lcnt == LCNT_W'(MAX_LOCK));

    // Reset blanks the mask so nothing, in particular no write, reaches the bank.
    always_comb begin
        w_mask  = 2'b00;
        w_break = 1'b0;
        if (rst_n) begin
            if (!w_locked) begin
                w_mask = 2'b11;
            end else if (w_lockExpired && w_req[!w_owner]) begin
                w_mask[!w_owner] = 1'b1;
                w_break          = 1'b1;
            end else begin
                w_mask[w_owner] = 1'b1;
            end
        end
    end

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (w_req),
        .i_mask (w_mask),
        .o_gnt  (w_gnt)
    );

    assign w_anyGnt  = |w_gnt;
    assign w_gntIdx  = w_gnt[1];
    assign w_gntLock = w_gntIdx ? r1_lock : r0_lock;
    assign r0_gnt    = w_gnt[0];
    assign r1_gnt    = w_gnt[1];

    always_comb begin
        mem_w_en = 1'b0;
        mem_addr = '0;
        mem_d_in = '0;
        if (w_anyGnt) begin
            mem_w_en = w_weIn[w_gntIdx];
            mem_addr = w_gntIdx ? r1_addr : r0_addr;
            mem_d_in = w_gntIdx ? r1_wdata : r0_wdata;
        end
    end

    // The lock counter keeps running across the owner's own locked accesses,
    // which is what bounds the other requester's wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_lcnt  <= '0;
        end else begin
            case (r_state)
                ARB_LOCK0, ARB_LOCK1: begin
                    if (w_break) begin
                        r_state <= w_gntLock ? lockStateOf(w_gntIdx) : ARB_IDLE;
                        r_lcnt  <= '0;
                    end else if (w_anyGnt && !w_gntLock) begin
                        r_state <= ARB_IDLE;
                        r_lcnt  <= '0;
                    end else if (!w_lockExpired) begin
                        r_lcnt <= r_lcnt + LCNT_W'(1);
                    end
                end
                default: begin
                    r_lcnt <= '0;
                    if (w_anyGnt && w_gntLock) begin
                        r_state <= lockStateOf(w_gntIdx);
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 2'b00;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_rvalid <= w_gnt & ~w_weIn;
            if (w_gnt[0] && !r0_we) begin
                r_rdata0 <= mem_d_out;
            end
            if (w_gnt[1] && !r1_we) begin
                r_rdata1 <= mem_d_out;
            end
        end
    end

    assign r0_rvalid = r_rvalid[0];
    assign r1_rvalid = r_rvalid[1];
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;

endmodule
